// File: rtl/mul_issue_arbiter.sv
// Two-port round-robin issue arbiter for a shared iterative RV32M multiplier.
// Accepts one op, runs it on the multiplier, then broadcasts the result on the CDB.
module mul_issue_arbiter #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             rq0_valid,
  output logic             rq0_ready,
  input  logic [2:0]       rq0_funct3,
  input  logic [31:0]      rq0_rs1,
  input  logic [31:0]      rq0_rs2,
  input  logic [TAG_W-1:0] rq0_tag,
  input  logic             rq1_valid,
  output logic             rq1_ready,
  input  logic [2:0]       rq1_funct3,
  input  logic [31:0]      rq1_rs1,
  input  logic [31:0]      rq1_rs2,
  input  logic [TAG_W-1:0] rq1_tag,
  output logic             mul_start,
  output logic [1:0]       mul_type,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_flush,
  input  logic [63:0]      mul_p,
  input  logic             mul_done,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // ready never depends on the transfer itself, and valid/payload stay stable until it.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             mul_start_q, mul_start_d;
  logic [1:0]       mul_type_q, mul_type_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             hi_sel_q, hi_sel_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [31:0]      cdb_data_q, cdb_data_d;

  logic             grant0, grant1, can_accept;
  logic [1:0]       sel_op;
  logic             unused_funct3_hi;

  // funct3[2] only distinguishes MUL* from DIV*, which never reach this block.
  assign unused_funct3_hi = rq0_funct3[2] ^ rq1_funct3[2];

  always_comb begin
    grant0     = rq0_valid & (~rq1_valid | last_grant_q);
    grant1     = rq1_valid & (~rq0_valid | ~last_grant_q);
    can_accept = (state_q == S_IDLE) & ~flush;
    rq0_ready  = can_accept & grant0;
    rq1_ready  = can_accept & grant1;
    sel_op     = rq1_ready ? rq1_funct3[1:0] : rq0_funct3[1:0];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mul_start_d  = mul_start_q;
    mul_type_d   = mul_type_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    tag_d        = tag_q;
    hi_sel_d     = hi_sel_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_data_d   = cdb_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (rq0_ready | rq1_ready) begin
          mul_a_d      = rq1_ready ? rq1_rs1 : rq0_rs1;
          mul_b_d      = rq1_ready ? rq1_rs2 : rq0_rs2;
          tag_d        = rq1_ready ? rq1_tag : rq0_tag;
          hi_sel_d     = (sel_op != 2'b00);
          // MULHU uses the unsigned encoding; only the upper half is kept.
          mul_type_d   = (sel_op == 2'b11) ? 2'b00 : sel_op;
          last_grant_d = rq1_ready;
          mul_start_d  = 1'b1;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mul_done) begin
          cdb_data_d  = hi_sel_q ? mul_p[63:32] : mul_p[31:0];
          mul_start_d = 1'b0;
          cdb_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (cdb_ready) begin
          cdb_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        mul_start_d = 1'b0;
        cdb_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    // Flush wins over everything; operands and round-robin pointer are left alone.
    if (flush) begin
      state_d     = S_IDLE;
      mul_start_d = 1'b0;
      cdb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      mul_start_q  <= 1'b0;
      mul_type_q   <= 2'b00;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      tag_q        <= '0;
      hi_sel_q     <= 1'b0;
      cdb_valid_q  <= 1'b0;
      cdb_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mul_start_q  <= mul_start_d;
      mul_type_q   <= mul_type_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      tag_q        <= tag_d;
      hi_sel_q     <= hi_sel_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_data_q   <= cdb_data_d;
    end
  end

  assign mul_start = mul_start_q;
  assign mul_type  = mul_type_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_flush = flush;
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = cdb_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Directed bench for mul_issue_arbiter with a latency-6 multiplier model and a
// scoreboard of expected CDB results.
module tb_mul_issue_arbiter;
  localparam int TAG_W = 5;
  localparam int LAT   = 6;

  logic             clk, rst, flush;
  logic             rq0_valid, rq0_ready, rq1_valid, rq1_ready;
  logic [2:0]       rq0_funct3, rq1_funct3;
  logic [31:0]      rq0_rs1, rq0_rs2, rq1_rs1, rq1_rs2;
  logic [TAG_W-1:0] rq0_tag, rq1_tag;
  logic             mul_start, mul_flush, mul_done;
  logic [1:0]       mul_type, dbg_state;
  logic [31:0]      mul_a, mul_b;
  logic [63:0]      mul_p;
  logic             cdb_valid, cdb_ready;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;

  logic [TAG_W+31:0] exp_q[$];
  logic [1:0]        exp_t_q[$];
  logic [63:0]       exp_ab_q[$];
  int n_checks = 0;
  int n_errors = 0;

  mul_issue_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_funct3(rq0_funct3),
    .rq0_rs1(rq0_rs1), .rq0_rs2(rq0_rs2), .rq0_tag(rq0_tag),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_funct3(rq1_funct3),
    .rq1_rs1(rq1_rs1), .rq1_rs2(rq1_rs2), .rq1_tag(rq1_tag),
    .mul_start(mul_start), .mul_type(mul_type), .mul_a(mul_a), .mul_b(mul_b),
    .mul_flush(mul_flush), .mul_p(mul_p), .mul_done(mul_done),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Multiplier model: done LAT cycles after start rises, held until start falls.
  function automatic logic [63:0] model_prod(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = {{32{(t != 2'b00) & a[31]}}, a};
    eb = {{32{(t == 2'b01) & b[31]}}, b};
    return ea * eb;
  endfunction

  logic [7:0] m_cnt;
  always @(posedge clk) begin
    if (rst) mul_p <= '0;
    if (rst || mul_flush || !mul_start) begin
      m_cnt    <= '0;
      mul_done <= 1'b0;
    end else if (!mul_done) begin
      if (m_cnt == 8'(LAT - 1)) begin
        mul_done <= 1'b1;
        mul_p    <= model_prod(mul_type, mul_a, mul_b);
      end else begin
        m_cnt <= m_cnt + 8'd1;
      end
    end
  end

  // Reference RV32M semantics
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3[1:0])
      2'b00:   p = ua * ub;
      2'b01:   p = sa * sb;
      2'b10:   p = sa * $signed(ub);
      default: p = ua * ub;
    endcase
    return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [1:0] ref_type(input logic [2:0] f3);
    return (f3[1:0] == 2'b11) ? 2'b00 : f3[1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_rq(input int port, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag, input bit push);
    if (port == 0) begin
      rq0_funct3 = f3; rq0_rs1 = a; rq0_rs2 = b; rq0_tag = tag; rq0_valid = 1'b1;
    end else begin
      rq1_funct3 = f3; rq1_rs1 = a; rq1_rs2 = b; rq1_tag = tag; rq1_valid = 1'b1;
    end
    exp_t_q.push_back(ref_type(f3));
    exp_ab_q.push_back({a, b});
    if (push) exp_q.push_back({tag, ref_result(f3, a, b)});
  endtask

  task automatic wait_accept(output int port, output int waited);
    logic [1:0]  t;
    logic [63:0] ab;
    port   = -1;
    waited = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (rq0_ready | rq1_ready) begin
        port = rq1_ready ? 1 : 0;
        break;
      end
      @(negedge clk);
      waited++;
    end
    if (port < 0) begin
      chk("accept_timeout", 64'd0, 64'd1);
      return;
    end
    chk("one_hot_ready", 64'(rq0_ready & rq1_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    t  = exp_t_q.pop_front();
    ab = exp_ab_q.pop_front();
    chk("start_after_accept", 64'(mul_start), 64'd1);
    chk("mul_type", 64'(mul_type), 64'(t));
    chk("mul_a", 64'(mul_a), 64'(ab[63:32]));
    chk("mul_b", 64'(mul_b), 64'(ab[31:0]));
    chk("state_busy", 64'(dbg_state), 64'd1);
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (mul_done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard pop: result must appear exactly one cycle after mul_done.
  task automatic wait_result(input int stall);
    bit got;
    logic [TAG_W+31:0] e;
    wait_done(got);
    if (!got) return;
    chk("cdb_valid_at_done", 64'(cdb_valid), 64'd0);
    chk("start_at_done", 64'(mul_start), 64'd1);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("cdb_valid_after_done", 64'(cdb_valid), 64'd1);
    chk("start_low_after_done", 64'(mul_start), 64'd0);
    chk("cdb_tag", 64'(cdb_tag), 64'(e[TAG_W+31:32]));
    chk("cdb_data", 64'(cdb_data), 64'(e[31:0]));
    if (stall > 0) begin
      rq0_valid = 1'b1;
      rq1_valid = 1'b1;
      for (int k = 1; k <= stall; k++) begin
        #1;
        chk("stall_rq_ready", 64'({rq0_ready, rq1_ready}), 64'd0);
        @(negedge clk);
        chk("stall_cdb_valid", 64'(cdb_valid), 64'd1);
        chk("stall_cdb_tag", 64'(cdb_tag), 64'(e[TAG_W+31:32]));
        chk("stall_cdb_data", 64'(cdb_data), 64'(e[31:0]));
        chk("stall_start_low", 64'(mul_start), 64'd0);
      end
      rq0_valid = 1'b0;
      rq1_valid = 1'b0;
      cdb_ready = 1'b1;
    end
  endtask

  initial begin
    int p, w;
    bit got;
    logic [2:0] f3;
    rst = 1'b1; flush = 1'b0; cdb_ready = 1'b1;
    rq0_valid = 1'b0; rq0_funct3 = '0; rq0_rs1 = '0; rq0_rs2 = '0; rq0_tag = '0;
    rq1_valid = 1'b0; rq1_funct3 = '0; rq1_rs1 = '0; rq1_rs2 = '0; rq1_tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_mul_type", 64'(mul_type), 64'd0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    chk("rst_cdb_data", 64'(cdb_data), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // First tie goes to port 0: MUL 3x5 tag 4 vs MULH on port 1.
    set_rq(0, 3'b000, 32'd3, 32'd5, 5'd4, 1'b1);
    set_rq(1, 3'b001, 32'hFFFF_FFFF, 32'd2, 5'd7, 1'b1);
    wait_accept(p, w);
    chk("first_tie_port", 64'(p), 64'd0);
    rq0_valid = 1'b0;
    wait_result(0);
    wait_accept(p, w);
    chk("mulh_port", 64'(p), 64'd1);
    chk("b2b_accept_gap", 64'(w), 64'd1);
    rq1_valid = 1'b0;
    wait_result(0);

    // MULHU with a 3-cycle CDB stall
    set_rq(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
    wait_accept(p, w);
    rq0_valid = 1'b0;
    cdb_ready = 1'b0;
    wait_result(3);

    // MULHSU on port 1 leaves last_grant at 1
    set_rq(1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1);
    wait_accept(p, w);
    chk("mulhsu_port", 64'(p), 64'd1);
    rq1_valid = 1'b0;
    wait_result(0);

    // Both ports valid for four ops: grants alternate 0,1,0,1
    f3 = 3'($urandom_range(0, 7));
    set_rq(0, f3, $urandom, $urandom, 5'd16, 1'b1);
    f3 = 3'($urandom_range(0, 7));
    set_rq(1, f3, $urandom, $urandom, 5'd17, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_accept(p, w);
      chk($sformatf("alt_grant_%0d", k), 64'(p), 64'(k % 2));
      if (k > 0) chk($sformatf("alt_gap_%0d", k), 64'(w), 64'd1);
      f3 = 3'($urandom_range(0, 7));
      if (p == 0) begin
        if (k + 2 < 4) set_rq(0, f3, $urandom, $urandom, 5'(18 + k), 1'b1);
        else rq0_valid = 1'b0;
      end else if (p == 1) begin
        if (k + 2 < 4) set_rq(1, f3, $urandom, $urandom, 5'(18 + k), 1'b1);
        else rq1_valid = 1'b0;
      end
      wait_result(0);
    end

    // Flush during BUSY
    set_rq(0, 3'b000, 32'd7, 32'd7, 5'd3, 1'b0);
    wait_accept(p, w);
    rq0_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_busy_mul_flush", 64'(mul_flush), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_start", 64'(mul_start), 64'd0);
    chk("flush_busy_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("flush_busy_state", 64'(dbg_state), 64'd0);
    // Flush in IDLE blocks the grant
    set_rq(1, 3'b001, 32'd100, 32'hFFFF_FFFE, 5'd12, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_idle_ready", 64'({rq0_ready, rq1_ready}), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle_no_start", 64'(mul_start), 64'd0);
    wait_accept(p, w);
    chk("accept_after_flush", 64'(w), 64'd0);
    rq1_valid = 1'b0;

    // Flush in OUT with cdb_ready low: result is dropped
    cdb_ready = 1'b0;
    wait_done(got);
    @(negedge clk);
    chk("out_before_flush", 64'(cdb_valid), 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_out_mul_flush", 64'(mul_flush), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    cdb_ready = 1'b1;
    chk("flush_out_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("flush_out_state", 64'(dbg_state), 64'd0);

    // last_grant kept through flush (was 1) so port 0 wins the tie
    set_rq(0, 3'b000, 32'h0001_0000, 32'h0001_0000, 5'd21, 1'b1);
    set_rq(1, 3'b011, 32'h8000_0000, 32'd4, 5'd22, 1'b1);
    wait_accept(p, w);
    chk("post_flush_port", 64'(p), 64'd0);
    chk("post_flush_gap", 64'(w), 64'd0);
    rq0_valid = 1'b0;
    wait_result(0);
    wait_accept(p, w);
    chk("post_flush_port1", 64'(p), 64'd1);
    rq1_valid = 1'b0;
    wait_result(0);

    @(negedge clk);
    chk("final_cdb_idle", 64'(cdb_valid), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mul_issue_arbiter.md
MUL_ISSUE_ARBITER -- requirements
Module: mul_issue_arbiter

Interface
REQ-001 The block SHALL have parameter TAG_W, default 5: ROB tag width.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port flush, input, 1 bit: pipeline flush (mispredict/exception).
REQ-005 For N=0,1, the block SHALL have port rqN_valid, input, 1 bit: requester N has a multiply op.
REQ-006 For N=0,1, the block SHALL have port rqN_ready, output, 1 bit: requester N's op is accepted this cycle when valid&ready.
REQ-007 For N=0,1, the block SHALL have port rqN_funct3, input, 3 bits: RV32M funct3; bits[1:0] decoded, bit 2 ignored.
REQ-008 For N=0,1, the block SHALL have ports rqN_rs1 and rqN_rs2, input, 32 bits each: operands.
REQ-009 For N=0,1, the block SHALL have port rqN_tag, input, TAG_W bits: destination ROB tag.
REQ-010 The block SHALL have port mul_start, output, 1 bit, registered: multiplier start level.
REQ-011 The block SHALL have port mul_type, output, 2 bits, registered: 00 unsigned×unsigned, 01 signed×signed, 10 signed×unsigned.
REQ-012 The block SHALL have ports mul_a and mul_b, output, 32 bits each, registered: multiplier operands.
REQ-013 The block SHALL have port mul_flush, output, 1 bit: multiplier flush, equal to flush, combinational.
REQ-014 The block SHALL have port mul_p, input, 64 bits: multiplier product.
REQ-015 The block SHALL have port mul_done, input, 1 bit: multiplier finished; held until mul_start falls.
REQ-016 The block SHALL have ports cdb_valid (output, 1 bit), cdb_ready (input, 1 bit), cdb_tag (output, TAG_W bits) and cdb_data (output, 32 bits): result broadcast.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, BUSY and OUT; IDLE is the reset state.
REQ-018 In IDLE, the block SHALL drive rqN_ready=1 only for the granted port; grant goes to the single valid port, or on a tie to the port not granted last (round-robin); last_grant resets to 1, so port 0 wins the first tie.
REQ-019 Outside IDLE, and in any cycle with flush=1, the block SHALL hold rq0_ready=rq1_ready=0.
REQ-020 On accept, the block SHALL latch rs1→mul_a, rs2→mul_b, tag, hi_sel=(funct3[1:0]!=00), update last_grant, set mul_start=1 and go to BUSY.
REQ-021 The block SHALL map funct3[1:0] to mul_type as follows: 00 MUL→00, 01 MULH→01, 10 MULHSU→10, 11 MULHU→00.
REQ-022 In BUSY, the block SHALL hold mul_start=1 and mul_a, mul_b, mul_type stable until mul_done=1.
REQ-023 On mul_done in BUSY, the block SHALL capture cdb_data = hi_sel ? mul_p[63:32] : mul_p[31:0], clear mul_start and go to OUT.
REQ-024 In OUT, the block SHALL hold cdb_valid=1 with cdb_tag and cdb_data stable until cdb_ready=1, then return to IDLE.
REQ-025 Controller overhead SHALL be: accept in cycle a gives mul_start=1 from cycle a+1; mul_done seen in cycle d gives cdb_valid=1 from cycle d+1 and mul_start=0 from cycle d+1.
REQ-026 The block SHALL guarantee mul_start is low for at least one cycle between ops (OUT occupies ≥1 cycle), so the multiplier returns to its idle state.
REQ-027 Back-to-back throughput SHALL be: with cdb_ready held high, the next accept is possible in cycle d+2.
REQ-028 The block SHALL ignore mul_done outside BUSY.

Reset
REQ-029 On rst (synchronous), the block SHALL set state=IDLE, mul_start=0, cdb_valid=0, last_grant=1, and clear mul_a, mul_b, mul_type, cdb_data and cdb_tag to 0.
REQ-030 On flush (same clock as a non-rst cycle), the block SHALL return to IDLE, set mul_start=0 and cdb_valid=0, and drop the in-flight op with no CDB broadcast.
REQ-031 flush SHALL have priority over a simultaneous accept, mul_done or cdb handshake; operand and last_grant registers SHALL keep their values.

Verification
REQ-032 The bench SHALL drive rq0 MUL 3×5 tag 4, with a model multiplier of latency 6 → mul_type=00, cdb_valid one cycle after mul_done, cdb_data=15, cdb_tag=4.
REQ-033 The bench SHALL drive MULH rs1=0xFFFFFFFF, rs2=2 → mul_type=01, cdb_data=0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → mul_type=00, cdb_data=0xFFFFFFFE.
REQ-034 The bench SHALL drive MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → mul_type=10, cdb_data=0xFFFFFFFF.
REQ-035 The bench SHALL hold rq0 and rq1 valid continuously for 4 ops → grants alternate 0,1,0,1, and each accepted cycle has exactly one ready high.
REQ-036 The bench SHALL assert flush during BUSY, then again in OUT with cdb_ready=0 → mul_flush=1 the same cycle, no cdb_valid for the flushed op, and the next accept is possible the following cycle.
REQ-037 The bench SHALL hold cdb_ready=0 for 3 cycles in OUT → cdb_valid, cdb_data and cdb_tag stay stable, mul_start stays 0, and both rqN_ready stay 0.
